// File: rtl/fb_pkg.sv
// Shared constants for the framebuffer window reader: scale codes, idle address, RGB332 colours.
// Optional test-pattern colours are used only when FB_TEST_PATTERN_EN is defined.
package fb_pkg;

    localparam logic [1:0] SCALE_1X = 2'd0;
    localparam logic [1:0] SCALE_2X = 2'd1;
    localparam logic [1:0] SCALE_4X = 2'd2;

    localparam logic [7:0] RGB_RED_MASK   = 8'hE0;
    localparam logic [7:0] RGB_GREEN_MASK = 8'h1C;
    localparam logic [7:0] RGB_BLUE_MASK  = 8'h03;

    localparam logic [7:0] BAR_WHITE   = RGB_RED_MASK | RGB_GREEN_MASK | RGB_BLUE_MASK;
    localparam logic [7:0] BAR_YELLOW  = RGB_RED_MASK | RGB_GREEN_MASK;
    localparam logic [7:0] BAR_CYAN    = RGB_GREEN_MASK | RGB_BLUE_MASK;
    localparam logic [7:0] BAR_GREEN   = RGB_GREEN_MASK;
    localparam logic [7:0] BAR_MAGENTA = RGB_RED_MASK | RGB_BLUE_MASK;
    localparam logic [7:0] BAR_RED     = RGB_RED_MASK;
    localparam logic [7:0] BAR_BLUE    = RGB_BLUE_MASK;
    localparam logic [7:0] BAR_BLACK   = 8'h00;

    localparam int BAR_WIDTH = 80;

    // Last pixel of the stored image; parked on it whenever the beam is outside the window.
    function automatic int addr_idle(input int cam_x, input int cam_y);
        return cam_x * cam_y - 1;
    endfunction

    function automatic logic [1:0] scale_shift(input logic [1:0] scale);
        case (scale)
            SCALE_2X: return 2'd1;
            SCALE_4X: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

    function automatic logic [7:0] bar_colour(input logic [3:0] idx);
        case (idx)
            4'd0:    return BAR_WHITE;
            4'd1:    return BAR_YELLOW;
            4'd2:    return BAR_CYAN;
            4'd3:    return BAR_GREEN;
            4'd4:    return BAR_MAGENTA;
            4'd5:    return BAR_RED;
            4'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/fb_delay_line.sv
// Fixed-depth register pipeline used to keep side-band data aligned with memory read data.
// Latency DEPTH cycles, no backpressure (advances every clock).
module fb_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/fb_window_reader.sv
// Framebuffer window address generator and pixel pipeline; latency RD_LAT+2, one pixel per clock, no stalls.
// Optional vertical colour-bar test pattern enabled by defining FB_TEST_PATTERN_EN.
module fb_window_reader
    import fb_pkg::*;
#(
    parameter int CAM_X  = 320,
    parameter int CAM_Y  = 240,
    parameter int AW     = 17,
    parameter int DW     = 8,
    parameter int XW     = 10,
    parameter int YW     = 9,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [XW-1:0] posX,
    input  logic [YW-1:0] posY,
    input  logic [1:0]    cfg_scale,
    input  logic [XW-1:0] cfg_off_x,
    input  logic [YW-1:0] cfg_off_y,
    input  logic [DW-1:0] cfg_border,
    input  logic          cfg_pattern,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic [DW-1:0] pixel_out,
    output logic          in_window
);

    localparam logic [AW-1:0]   ADDR_IDLE = AW'(addr_idle(CAM_X, CAM_Y));
    localparam logic [XW+2:0]   CAM_X_E   = (XW+3)'(CAM_X);
    localparam logic [YW+2:0]   CAM_Y_E   = (YW+3)'(CAM_Y);
    localparam int              PIPE      = RD_LAT + 1;

    logic [1:0]    sh_scale;
    logic [XW-1:0] sh_off_x;
    logic [YW-1:0] sh_off_y;
    logic [DW-1:0] sh_border;
    logic          frame_start;

    assign frame_start = (posX == '0) && (posY == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_scale  <= SCALE_1X;
            sh_off_x  <= '0;
            sh_off_y  <= '0;
            sh_border <= '0;
        end else if (frame_start) begin
            sh_scale  <= cfg_scale;
            sh_off_x  <= cfg_off_x;
            sh_off_y  <= cfg_off_y;
            sh_border <= cfg_border;
        end
    end

    // Window bounds carry three extra bits so off + (CAM << 2) cannot wrap.
    logic [1:0]    sh;
    logic [XW+2:0] px_e, ox_e, span_x, dx, col;
    logic [YW+2:0] py_e, oy_e, span_y, dy, row;
    logic          in_x, in_y, win_now;
    logic [AW-1:0] addr_nxt;

    always_comb begin
        sh       = scale_shift(sh_scale);
        px_e     = {3'b000, posX};
        py_e     = {3'b000, posY};
        ox_e     = {3'b000, sh_off_x};
        oy_e     = {3'b000, sh_off_y};
        span_x   = CAM_X_E << sh;
        span_y   = CAM_Y_E << sh;
        in_x     = (px_e >= ox_e) && (px_e < ox_e + span_x);
        in_y     = (py_e >= oy_e) && (py_e < oy_e + span_y);
        win_now  = in_x && in_y;
        dx       = px_e - ox_e;
        dy       = py_e - oy_e;
        col      = dx >> sh;
        row      = dy >> sh;
        addr_nxt = ADDR_IDLE;
        if (win_now) addr_nxt = AW'(row) * AW'(CAM_X) + AW'(col);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_addr <= ADDR_IDLE;
        else     mem_addr <= addr_nxt;
    end

    logic win_d;

    fb_delay_line #(.W(1), .DEPTH(PIPE)) u_win_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (win_now),
        .dout (win_d)
    );

    logic [DW-1:0] src_pix;

`ifdef FB_TEST_PATTERN_EN
    logic          sh_pattern;
    logic [9:0]    px10;
    logic [DW-1:0] bar_now, bar_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              sh_pattern <= 1'b0;
        else if (frame_start) sh_pattern <= cfg_pattern;
    end

    assign px10    = posX[9:0];
    assign bar_now = DW'(bar_colour(4'(px10 / 10'(BAR_WIDTH))));

    fb_delay_line #(.W(DW), .DEPTH(PIPE)) u_bar_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (bar_now),
        .dout (bar_d)
    );

    assign src_pix = sh_pattern ? bar_d : mem_data;
`else
    logic cfg_pattern_unused;
    assign cfg_pattern_unused = cfg_pattern;
    assign src_pix            = mem_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_out <= '0;
            in_window <= 1'b0;
        end else begin
            pixel_out <= win_d ? src_pix : sh_border;
            in_window <= win_d;
        end
    end

endmodule

// File: tb/tb_fb_window_reader.sv
// Directed, table-driven bench for fb_window_reader with a synchronous RAM model of RD_LAT cycles.
module tb_fb_window_reader;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  posX;
    logic [8:0]  posY;
    logic [1:0]  cfg_scale;
    logic [9:0]  cfg_off_x;
    logic [8:0]  cfg_off_y;
    logic [7:0]  cfg_border;
    logic        cfg_pattern;
    logic [16:0] mem_addr;
    logic [7:0]  mem_data;
    logic [7:0]  pixel_out;
    logic        in_window;

    always #20 clk = ~clk;

    fb_window_reader #(
        .CAM_X(320), .CAM_Y(240), .AW(17), .DW(8), .XW(10), .YW(9), .RD_LAT(RD_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .posX       (posX),
        .posY       (posY),
        .cfg_scale  (cfg_scale),
        .cfg_off_x  (cfg_off_x),
        .cfg_off_y  (cfg_off_y),
        .cfg_border (cfg_border),
        .cfg_pattern(cfg_pattern),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .pixel_out  (pixel_out),
        .in_window  (in_window)
    );

    // Memory contents: low address byte XOR 0x20 (address 645 holds 0xA5).
    function automatic logic [7:0] fmem(input logic [16:0] a);
        return a[7:0] ^ 8'h20;
    endfunction

    logic [7:0] mq [RD_LAT];
    always @(posedge clk) begin
        mq[0] <= fmem(mem_addr);
        for (int i = 1; i < RD_LAT; i++) mq[i] <= mq[i-1];
    end
    assign mem_data = mq[RD_LAT-1];

    typedef struct {
        logic [1:0]  scale;
        logic [9:0]  ox;
        logic [8:0]  oy;
        logic [7:0]  border;
        logic        pat;
        logic [9:0]  x;
        logic [8:0]  y;
        logic [16:0] addr;
        logic        win;
        logic [7:0]  pix;
    } vec_t;

    vec_t vq[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add(input logic [1:0] s, input logic [9:0] ox, input logic [8:0] oy,
                       input logic [7:0] b, input logic p, input logic [9:0] x, input logic [8:0] y,
                       input logic [16:0] a, input logic w, input logic [7:0] px);
        vec_t v;
        v.scale = s; v.ox = ox; v.oy = oy; v.border = b; v.pat = p;
        v.x = x; v.y = y; v.addr = a; v.win = w; v.pix = px;
        vq.push_back(v);
    endtask

    task automatic frame_start(input logic [1:0] s, input logic [9:0] ox, input logic [8:0] oy,
                               input logic [7:0] b, input logic p);
        cfg_scale = s; cfg_off_x = ox; cfg_off_y = oy; cfg_border = b; cfg_pattern = p;
        posX = '0; posY = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    // Drives one position and checks address after one edge, pixel/flag after RD_LAT+2 edges.
    task automatic apply(input string tag, input logic [9:0] x, input logic [8:0] y,
                         input logic [16:0] a, input logic w, input logic [7:0] px);
        posX = x; posY = y;
        @(posedge clk); #1;
        check({tag, " mem_addr"}, 32'(mem_addr), 32'(a));
        repeat (RD_LAT + 1) @(posedge clk);
        #1;
        check({tag, " pixel_out"}, 32'(pixel_out), 32'(px));
        check({tag, " in_window"}, 32'(in_window), 32'(w));
        @(negedge clk);
    endtask

    logic [7:0] p0, p85, p639;

    initial begin
        rst = 1'b1;
        posX = 10'($urandom_range(0, 1023)); posY = 9'($urandom_range(0, 511));
        cfg_scale = 2'd0; cfg_off_x = '0; cfg_off_y = '0; cfg_border = '0; cfg_pattern = 1'b0;
        repeat (3) @(negedge clk);
        check("reset mem_addr", 32'(mem_addr), 32'd76799);
        check("reset pixel_out", 32'(pixel_out), 32'd0);
        check("reset in_window", 32'(in_window), 32'd0);
        rst = 1'b0;

`ifdef FB_TEST_PATTERN_EN
        p0 = 8'hFF; p85 = 8'hFC; p639 = 8'h00;
`else
        p0 = 8'hA0; p85 = 8'h8A; p639 = 8'h9F;
`endif
        //  scale ox      oy      border pat x        y       addr      win  pix
        add(2'd0, 10'd0,   9'd0,   8'h00, 0, 10'd5,   9'd2,   17'd645,   1, 8'hA5);
        add(2'd1, 10'd0,   9'd0,   8'h00, 0, 10'd639, 9'd479, 17'd76799, 1, 8'hDF);
        add(2'd1, 10'd0,   9'd0,   8'h00, 0, 10'd3,   9'd1,   17'd1,     1, 8'h21);
        add(2'd0, 10'd160, 9'd120, 8'h1C, 0, 10'd100, 9'd50,  17'd76799, 0, 8'h1C);
        add(2'd0, 10'd160, 9'd120, 8'h1C, 0, 10'd160, 9'd120, 17'd0,     1, 8'h20);
        add(2'd0, 10'd160, 9'd120, 8'h1C, 0, 10'd480, 9'd120, 17'd76799, 0, 8'h1C);
        add(2'd0, 10'd160, 9'd120, 8'h1C, 0, 10'd479, 9'd359, 17'd76799, 1, 8'hDF);
        add(2'd2, 10'd0,   9'd0,   8'h00, 0, 10'd639, 9'd479, 17'd38239, 1, 8'h7F);
        add(2'd3, 10'd0,   9'd0,   8'hE0, 0, 10'd400, 9'd10,  17'd76799, 0, 8'hE0);
        add(2'd1, 10'd600, 9'd400, 8'h03, 0, 10'd599, 9'd400, 17'd76799, 0, 8'h03);
        add(2'd1, 10'd600, 9'd400, 8'h03, 0, 10'd600, 9'd400, 17'd0,     1, 8'h20);
        add(2'd1, 10'd600, 9'd400, 8'h03, 0, 10'd639, 9'd479, 17'd12499, 1, 8'hF3);
        add(2'd0, 10'd1000, 9'd0,  8'h00, 0, 10'd1010, 9'd5,  17'd1610,  1, 8'h6A);
        add(2'd1, 10'd0,   9'd0,   8'h55, 1, 10'd0,   9'd5,   17'd640,   1, p0);
        add(2'd1, 10'd0,   9'd0,   8'h55, 1, 10'd85,  9'd5,   17'd682,   1, p85);
        add(2'd1, 10'd0,   9'd0,   8'h55, 1, 10'd639, 9'd5,   17'd959,   1, p639);

        @(negedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            frame_start(vq[i].scale, vq[i].ox, vq[i].oy, vq[i].border, vq[i].pat);
            apply($sformatf("vec%0d", i), vq[i].x, vq[i].y, vq[i].addr, vq[i].win, vq[i].pix);
        end

        // Scale change mid-frame must wait for the next (0,0).
        frame_start(2'd0, 10'd0, 9'd0, 8'h00, 1'b0);
        apply("midframe 1x", 10'd3, 9'd100, 17'd32003, 1, 8'h23);
        cfg_scale = 2'd1;
        repeat (4) @(negedge clk);
        apply("midframe held", 10'd3, 9'd100, 17'd32003, 1, 8'h23);
        frame_start(2'd1, 10'd0, 9'd0, 8'h00, 1'b0);
        apply("next frame 2x", 10'd3, 9'd100, 17'd16001, 1, 8'hA1);

        // Reset mid-frame: outputs clear at once, shadows revert to 1x/offset 0/border 0.
        frame_start(2'd0, 10'd160, 9'd120, 8'h1C, 1'b0);
        apply("pre-reset", 10'd100, 9'd50, 17'd76799, 0, 8'h1C);
        rst = 1'b1;
        #1;
        check("midreset mem_addr", 32'(mem_addr), 32'd76799);
        check("midreset pixel_out", 32'(pixel_out), 32'd0);
        check("midreset in_window", 32'(in_window), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply("post-reset shadow", 10'd100, 9'd50, 17'd16100, 1, 8'hC4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fb_window_reader.md
# fb_window_reader

Framebuffer read-side address generator and pixel pipeline between the dual-port frame buffer and the 640x480 VGA driver. It replaces the fixed 320x240, top-left, last-pixel-fill mapping with a parametrised camera image size, runtime scale (1x/2x/4x), runtime X/Y placement offset and a programmable border colour. It compensates memory read latency so that `pixel_out` is aligned with a fixed, documented delay from the position inputs. Configuration is shadowed at frame start so changes never tear an image.

## Interface
Parameters:
- `CAM_X`, 320, stored image width in pixels
- `CAM_Y`, 240, stored image height in pixels
- `AW`, 17, memory address width; must satisfy 2^AW ≥ CAM_X*CAM_Y
- `DW`, 8, pixel width (RGB332)
- `XW`, 10, width of the VGA X position
- `YW`, 9, width of the VGA Y position
- `RD_LAT`, 1, read latency of the buffer from address to data, in clk cycles (1..4)

Ports:
- `clk` in 1: pixel clock, 25 MHz. Single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `posX` in XW: X position of the next VGA pixel.
- `posY` in YW: Y position of the next VGA pixel.
- `cfg_scale` in 2: scale code. 0 = 1x, 1 = 2x, 2 = 4x, 3 = reserved (treated as 1x).
- `cfg_off_x` in XW: left edge of the image window.
- `cfg_off_y` in YW: top edge of the image window.
- `cfg_border` in DW: colour shown outside the window.
- `cfg_pattern` in 1: selects the test pattern. Ignored unless FB_TEST_PATTERN_EN is defined.
- `mem_addr` out AW: read address to the buffer.
- `mem_data` in DW: read data from the buffer.
- `pixel_out` out DW: pixel to the VGA driver.
- `in_window` out 1: high when `pixel_out` comes from memory. Aligned with `pixel_out`.

## Operation
- **Shadow registers.** The block keeps shadow copies of scale, off_x, off_y, border and pattern.
  - They load from the cfg_* inputs on any cycle where posX==0 and posY==0.
  - On reset they hold: 1x, offset 0, border 0, pattern 0.
  - All window arithmetic uses the shadow values only.
- **Scale.** sh = 0, 1 or 2 for 1x, 2x and 4x.
- **Window test.**
  - Window is off_x ≤ posX < off_x + (CAM_X<<sh) and off_y ≤ posY < off_y + (CAM_Y<<sh).
  - Bounds are evaluated in XW+3 / YW+3 bits, so the window edges never wrap.
  - A window extending past the screen is clipped implicitly.
- **Inside the window.** col = (posX−off_x)>>sh, row = (posY−off_y)>>sh, mem_addr = row*CAM_X + col.
- **Outside the window.** mem_addr = ADDR_IDLE = CAM_X*CAM_Y−1, and pixel_out = shadow border.
- **Data path.** The window flag is delayed by RD_LAT+1 stages. When the delayed flag is 1, pixel_out = mem_data; otherwise pixel_out = border.
- **Blanking.** Positions beyond 639/479 are outside any valid window only if the window math says so. No special-casing of blanking is done; the VGA driver masks it.

## Timing
- Cycle n: posX/posY presented.
- Edge n+1: mem_addr registered.
- Edge n+1+RD_LAT: mem_data valid.
- Edge n+2+RD_LAT: pixel_out and in_window registered. Total latency L = RD_LAT+2.
- The VGA driver must advance posX by L ahead of the displayed pixel.
- Throughput is one pixel per clk, with no stalls.
- Reset values: mem_addr = ADDR_IDLE, pixel_out = 0, in_window = 0, all pipeline stages cleared.
- Reset mid-frame: outputs return to their reset values immediately. Shadows revert to defaults until the next (0,0).
- cfg_* changes mid-frame have no effect until the next posX==0 && posY==0.
- Frame start with the position held at (0,0) for several cycles: the shadows reload every cycle. This is harmless.

## Configuration
- `FB_TEST_PATTERN_EN` defined:
  - When shadow pattern = 1, pixel_out replaces mem_data with 8 vertical colour bars. Each bar is 80 px wide, selected by posX[9:0]/80 and delayed with the pipeline.
  - Bar colours in order: FF, FC, 1F, 1C, E3, E0, 03, 00.
  - The border still applies outside the window. in_window is unchanged.
- `FB_TEST_PATTERN_EN` undefined: the pattern logic is absent and `cfg_pattern` is unused.

## Structure
- Shared package `fb_pkg` holds:
  - scale code constants (SCALE_1X, SCALE_2X, SCALE_4X);
  - the ADDR_IDLE computation;
  - the RGB332 colour constants (the RED/GREEN/BLUE masks and the bar colours).
- Sub-module `fb_delay_line` is a parametrised width/depth register pipeline with asynchronous reset. It is used for the window flag and the bar colour.

## Test plan
1. **Reset.** Assert rst with random posX/posY → mem_addr = 76799, pixel_out = 0, in_window = 0. Pass through one frame start with all cfg_* = 0.
2. **1x, offset 0.** Pos (5,2) → mem_addr = 645 at n+1. Drive mem_data = 0xA5 → pixel_out = 0xA5 and in_window = 1 at n+RD_LAT+2.
3. **2x, offset 0.** Pos (639,479) → mem_addr = 76799, in_window = 1. Pos (3,1) → mem_addr = 1.
4. **1x, offset (160,120), border 0x1C.**
   - Pos (100,50) → mem_addr = 76799, pixel_out = 0x1C, in_window = 0.
   - Pos (160,120) → mem_addr = 0.
   - Pos (480,120) → outside the window.
5. **Mid-frame config change.** Change cfg_scale to 2x at posY = 100 → addresses stay 1x until (0,0). They become 2x on the following frame.
6. **Pattern (FB_TEST_PATTERN_EN defined).** With pattern = 1, pos x = 0, 85, 639 → pixel_out = FF, FC, 00. With the macro undefined → memory data is shown.
